// File: rtl/int_bus_pkg.sv
// Types and defaults shared by the bus interrupt controller and the CPU-side
// acknowledge sequencer.
package int_bus_pkg;

  localparam int VEC_W = 3;
  localparam int BUS_W = 16;

  localparam logic [BUS_W-1:0] DEF_VEC_BASE   = 16'h0038;
  localparam logic [BUS_W-1:0] DEF_NMI_ADDR   = 16'h0066;
  localparam int               DEF_VEC_STRIDE = 8;
  localparam int               DEF_ACK_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    DELIVER = 2'd2
  } int_state_e;

  // Stride is a power of two, so the multiply reduces to a shift.
  function automatic logic [BUS_W-1:0] vec_addr(input logic [BUS_W-1:0] base,
                                                input logic [VEC_W-1:0] vec,
                                                input int stride);
    return base + (BUS_W'(vec) * BUS_W'(stride));
  endfunction

endpackage

// File: rtl/int_edge_detect.sv
// Falling-edge detector with a sticky pending flag. o_fire also covers an edge
// seen this cycle, so a consumer can act on it without waiting a cycle.
module int_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig_n,
  input  logic i_clr,
  output logic o_fire
);

  logic r_sig_q;
  logic r_pend;
  logic w_fall;

  assign w_fall = r_sig_q & ~i_sig_n;
  assign o_fire = r_pend | w_fall;

  // A consumed edge clears the flag; further edges before that merge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_q <= 1'b1;
      r_pend  <= 1'b0;
    end else begin
      r_sig_q <= i_sig_n;
      r_pend  <= (r_pend | w_fall) & ~i_clr;
    end
  end

endmodule

// File: rtl/int_ack_sequencer.sv
// CPU-side interrupt acknowledge sequencer: runs the int_ack_n window, captures
// the vector and presents a handler address to the core.
//   state   | meaning
//   IDLE    | waiting for NMI or enabled maskable request at an instruction boundary
//   ACK     | int_ack_n held low, vector captured on the final edge
//   DELIVER | irq_valid high, outputs held until irq_taken
module int_ack_sequencer
  import int_bus_pkg::*;
#(
  parameter int               ACK_CYCLES = DEF_ACK_CYCLES,
  parameter logic [BUS_W-1:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int               VEC_STRIDE = DEF_VEC_STRIDE,
  parameter logic [BUS_W-1:0] NMI_ADDR   = DEF_NMI_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             int_n,
  input  logic             nmi_n,
  input  logic [BUS_W-1:0] data_bus,
  output logic             int_ack_n,
  input  logic             ie,
  input  logic             core_ready,
  output logic             irq_valid,
  input  logic             irq_taken,
  output logic             is_nmi,
  output logic [VEC_W-1:0] irq_vector,
  output logic [BUS_W-1:0] handler_addr,
  output logic [15:0]      taken_count
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_ACK     = ACK;
  localparam logic [1:0] ST_DELIVER = DELIVER;
  localparam logic [3:0] ACK_LOAD   = 4'(ACK_CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_ack_cnt;
  logic             r_int_ack_n;
  logic             r_irq_valid;
  logic             r_is_nmi;
  logic [VEC_W-1:0] r_irq_vector;
  logic [BUS_W-1:0] r_handler_addr;
  logic [15:0]      r_taken_count;

  logic w_nmi_fire;
  logic w_nmi_clr;
  logic w_unused_bus;

  assign w_unused_bus = ^data_bus[BUS_W-1:VEC_W];
  assign w_nmi_clr    = (r_state == ST_IDLE) & w_nmi_fire & core_ready;

  int_edge_detect u_nmi_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig_n (nmi_n),
    .i_clr   (w_nmi_clr),
    .o_fire  (w_nmi_fire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_ack_cnt      <= 4'd0;
      r_int_ack_n    <= 1'b1;
      r_irq_valid    <= 1'b0;
      r_is_nmi       <= 1'b0;
      r_irq_vector   <= '0;
      r_handler_addr <= '0;
      r_taken_count  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_nmi_fire && core_ready) begin
            r_state        <= ST_DELIVER;
            r_irq_valid    <= 1'b1;
            r_is_nmi       <= 1'b1;
            r_irq_vector   <= '0;
            r_handler_addr <= NMI_ADDR;
          end else if (!int_n && ie && core_ready) begin
            r_state     <= ST_ACK;
            r_int_ack_n <= 1'b0;
            r_ack_cnt   <= ACK_LOAD;
          end
        end
        // Terminal count at zero keeps int_ack_n low for exactly ACK_CYCLES.
        ST_ACK: begin
          if (r_ack_cnt == 4'd0) begin
            r_state        <= ST_DELIVER;
            r_int_ack_n    <= 1'b1;
            r_irq_valid    <= 1'b1;
            r_is_nmi       <= 1'b0;
            r_irq_vector   <= data_bus[VEC_W-1:0];
            r_handler_addr <= vec_addr(VEC_BASE, data_bus[VEC_W-1:0], VEC_STRIDE);
          end else begin
            r_ack_cnt <= r_ack_cnt - 4'd1;
          end
        end
        ST_DELIVER: begin
          if (irq_taken) begin
            r_state       <= ST_IDLE;
            r_irq_valid   <= 1'b0;
            r_taken_count <= r_taken_count + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign int_ack_n    = r_int_ack_n;
  assign irq_valid    = r_irq_valid;
  assign is_nmi       = r_is_nmi;
  assign irq_vector   = r_irq_vector;
  assign handler_addr = r_handler_addr;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Directed bench for int_ack_sequencer with default parameters
// (ACK_CYCLES=2, VEC_BASE=0x0038, VEC_STRIDE=8, NMI_ADDR=0x0066).
module tb_int_ack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_n;
  logic        nmi_n;
  logic [15:0] data_bus;
  logic        int_ack_n;
  logic        ie;
  logic        core_ready;
  logic        irq_valid;
  logic        irq_taken;
  logic        is_nmi;
  logic [2:0]  irq_vector;
  logic [15:0] handler_addr;
  logic [15:0] taken_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int_ack_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .int_n        (int_n),
    .nmi_n        (nmi_n),
    .data_bus     (data_bus),
    .int_ack_n    (int_ack_n),
    .ie           (ie),
    .core_ready   (core_ready),
    .irq_valid    (irq_valid),
    .irq_taken    (irq_taken),
    .is_nmi       (is_nmi),
    .irq_vector   (irq_vector),
    .handler_addr (handler_addr),
    .taken_count  (taken_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; int_n = 1'b0; nmi_n = 1'b1; data_bus = 16'h0000;
    ie = 1'b1; core_ready = 1'b1; irq_taken = 1'b0;

    // reset held with int_n asserted
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_ack_n", 16'(int_ack_n), 16'h1);
      chk("rst_valid", 16'(irq_valid), 16'h0);
      chk("rst_count", taken_count, 16'h0);
    end
    chk("rst_is_nmi", 16'(is_nmi), 16'h0);
    chk("rst_vector", 16'(irq_vector), 16'h0);
    chk("rst_addr", handler_addr, 16'h0);
    int_n = 1'b1; rst_n = 1'b1;
    step(2);
    chk("idle_ack_n", 16'(int_ack_n), 16'h1);

    // maskable, vector 5
    int_n = 1'b0; data_bus = 16'h0005;
    step(1);
    chk("m5_ack_c1", 16'(int_ack_n), 16'h0);
    chk("m5_valid_c1", 16'(irq_valid), 16'h0);
    int_n = 1'b1;
    step(1);
    chk("m5_ack_c2", 16'(int_ack_n), 16'h0);
    chk("m5_valid_c2", 16'(irq_valid), 16'h0);
    step(1);
    chk("m5_ack_c3", 16'(int_ack_n), 16'h1);
    chk("m5_valid_c3", 16'(irq_valid), 16'h1);
    chk("m5_vector", 16'(irq_vector), 16'h5);
    chk("m5_addr", handler_addr, 16'h0060);
    chk("m5_is_nmi", 16'(is_nmi), 16'h0);
    data_bus = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_valid", 16'(irq_valid), 16'h1);
      chk("hold_addr", handler_addr, 16'h0060);
      chk("hold_vector", 16'(irq_vector), 16'h5);
    end
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0;
    chk("m5_taken_valid", 16'(irq_valid), 16'h0);
    chk("m5_count", taken_count, 16'h1);

    // masked by ie=0
    ie = 1'b0; int_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("masked_ack_n", 16'(int_ack_n), 16'h1);
    end
    ie = 1'b1; data_bus = 16'hFFFB;
    step(1);
    chk("unmask_ack_n", 16'(int_ack_n), 16'h0);
    int_n = 1'b1;
    step(2);
    chk("m3_valid", 16'(irq_valid), 16'h1);
    chk("m3_vector", 16'(irq_vector), 16'h3);
    chk("m3_addr", handler_addr, 16'h0050);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0;
    chk("m3_count", taken_count, 16'h2);

    // NMI and maskable in the same cycle
    nmi_n = 1'b0; int_n = 1'b0; data_bus = 16'h0001;
    step(1);
    chk("sim_valid", 16'(irq_valid), 16'h1);
    chk("sim_is_nmi", 16'(is_nmi), 16'h1);
    chk("sim_addr", handler_addr, 16'h0066);
    chk("sim_vector", 16'(irq_vector), 16'h0);
    chk("sim_ack_n", 16'(int_ack_n), 16'h1);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0; nmi_n = 1'b1;
    chk("sim_count", taken_count, 16'h3);
    chk("sim_idle_ack_n", 16'(int_ack_n), 16'h1);
    step(1);
    chk("sim_m_ack_n", 16'(int_ack_n), 16'h0);
    int_n = 1'b1;
    step(2);
    chk("sim_m_valid", 16'(irq_valid), 16'h1);
    chk("sim_m_is_nmi", 16'(is_nmi), 16'h0);
    chk("sim_m_addr", handler_addr, 16'h0040);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0;
    chk("sim_m_count", taken_count, 16'h4);

    // NMI edges during ACK and DELIVER merge into one delivery
    int_n = 1'b0; data_bus = 16'h0007;
    step(1);
    chk("na_ack_c1", 16'(int_ack_n), 16'h0);
    nmi_n = 1'b0; int_n = 1'b1;
    step(1);
    chk("na_ack_c2", 16'(int_ack_n), 16'h0);
    nmi_n = 1'b1;
    step(1);
    chk("na_m_valid", 16'(irq_valid), 16'h1);
    chk("na_m_is_nmi", 16'(is_nmi), 16'h0);
    chk("na_m_addr", handler_addr, 16'h0070);
    nmi_n = 1'b0;
    step(1);
    nmi_n = 1'b1;
    step(1);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0;
    chk("na_m_count", taken_count, 16'h5);
    step(1);
    chk("na_n_valid", 16'(irq_valid), 16'h1);
    chk("na_n_is_nmi", 16'(is_nmi), 16'h1);
    chk("na_n_addr", handler_addr, 16'h0066);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0;
    chk("na_n_count", taken_count, 16'h6);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("na_single", 16'(irq_valid), 16'h0);
    end

    // core not ready blocks the acknowledge
    core_ready = 1'b0; int_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("nrdy_ack_n", 16'(int_ack_n), 16'h1);
    end
    core_ready = 1'b1; data_bus = 16'h0005;

    // reset mid-ACK
    step(1);
    chk("ra_ack_n", 16'(int_ack_n), 16'h0);
    rst_n = 1'b0; int_n = 1'b1;
    step(1);
    chk("ra_released", 16'(int_ack_n), 16'h1);
    chk("ra_valid", 16'(irq_valid), 16'h0);
    chk("ra_count", taken_count, 16'h0);
    rst_n = 1'b1;
    step(2);

    // taken_count wrap from a preloaded 0xFFFF
    force dut.r_taken_count = 16'hFFFF;
    #1 release dut.r_taken_count;
    chk("wrap_preload", taken_count, 16'hFFFF);
    nmi_n = 1'b0;
    step(1);
    chk("wrap_valid", 16'(irq_valid), 16'h1);
    irq_taken = 1'b1;
    step(1);
    irq_taken = 1'b0; nmi_n = 1'b1;
    chk("wrap_count", taken_count, 16'h0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
